// File: rtl/seq_mcycle_ctrl_pkg.sv
// Shared types and width helpers for the machine-cycle sequencer.
`default_nettype none

package seq_mcycle_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        RUN      = 2'd0,
        HALT     = 2'd1,
        STOP     = 2'd2,
        OSC_WAIT = 2'd3
    } seq_mode_t;

    // A two-phase cycle still needs one bit of T-phase.
    function automatic int tph_width(input int t_per_m);
        return (t_per_m <= 2) ? 1 : $clog2(t_per_m);
    endfunction

    localparam int T_PER_M_DEF = 4;
    localparam int TPH_W_DEF   = tph_width(T_PER_M_DEF);

endpackage

`default_nettype wire

// File: rtl/seq_mcycle_ctrl_nmi_sync.sv
// NMI synchroniser with rising-edge detect and a pending flag where a new edge beats a clear.
`default_nettype none

module seq_nmi_sync (
    input  logic CLK,
    input  logic RESET,
    input  logic SYNC_RESET,
    input  logic nmi_i,
    input  logic clr_i,
    output logic pending_o
);

    logic [1:0] sync_q;
    logic       dly_q;
    logic       pending_q;
    logic       rise;

    assign rise      = sync_q[1] & ~dly_q;
    assign pending_o = pending_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q    <= '0;
            dly_q     <= 1'b0;
            pending_q <= 1'b0;
        end else if (SYNC_RESET) begin
            sync_q    <= '0;
            dly_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], nmi_i};
            dly_q     <= sync_q[1];
            pending_q <= rise | (pending_q & ~clr_i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_mcycle_ctrl.sv
// Machine-cycle sequencer: T-phase/wait counting, M-cycle state, low-power modes and interrupt entry.
`default_nettype none

module seq_mcycle_ctrl
    import seq_mcycle_ctrl_pkg::*;
#(
    parameter int STATE_W         = 3,
    parameter int T_PER_M         = 4,
    parameter int WAIT_MAX        = 3,
    parameter int OSC_WAIT_CYCLES = 16
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            SYNC_RESET,
    input  logic [STATE_W-1:0]              state_next,
    input  logic                            cond_fail,
    input  logic                            m_last,
    input  logic                            halt_op,
    input  logic                            stop_op,
    input  logic                            addr_valid,
    input  logic                            bus_rd,
    input  logic                            bus_wait,
    input  logic                            irq_pending,
    input  logic                            NMI,
    input  logic                            WAKE,
    input  logic                            OSC_STABLE,
    output logic [STATE_W-1:0]              state,
    output logic [tph_width(T_PER_M)-1:0]   tphase,
    output logic                            m_end,
    output logic [MODE_W-1:0]               mode,
    output logic                            CLK_ENA,
    output logic                            OSC_ENA,
    output logic                            RD,
    output logic                            MREQ,
    output logic                            int_entry,
    output logic                            int_is_nmi,
    output logic                            wait_timeout
);

    localparam int TPH_W  = tph_width(T_PER_M);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam int OSC_W  = $clog2(OSC_WAIT_CYCLES + 1);

    localparam logic [TPH_W-1:0]  TPH_LAST = TPH_W'(T_PER_M - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);
    localparam logic [OSC_W-1:0]  OSC_LAST = OSC_W'(OSC_WAIT_CYCLES - 1);

    seq_mode_t           mode_q;
    logic [TPH_W-1:0]    tphase_q, tphase_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [OSC_W-1:0]    osc_cnt_q;
    logic [STATE_W-1:0]  state_q, state_d;
    logic                clk_ena_q, osc_ena_q, rd_q, mreq_q;
    logic                int_entry_q, int_is_nmi_q, wait_timeout_q;

    logic nmi_pending;
    logic is_run, at_last, bus_busy, stall, forced, m_end_w, boundary;
    logic take_nmi, take_irq, enter_halt, enter_stop, run_next;

    seq_nmi_sync u_nmi_sync (
        .CLK        (CLK),
        .RESET      (RESET),
        .SYNC_RESET (SYNC_RESET),
        .nmi_i      (NMI),
        .clr_i      (take_nmi),
        .pending_o  (nmi_pending)
    );

    always_comb begin
        is_run     = (mode_q == RUN);
        at_last    = is_run && (tphase_q == TPH_LAST);
        bus_busy   = addr_valid && bus_wait;
        stall      = at_last && bus_busy && (wait_cnt_q < WAIT_LIM);
        forced     = at_last && bus_busy && (wait_cnt_q == WAIT_LIM);
        m_end_w    = at_last && !stall;
        boundary   = m_end_w && m_last;
        // Interrupts outrank HALT/STOP, so a pending interrupt never lets the core sleep.
        take_nmi   = boundary && nmi_pending;
        take_irq   = boundary && !nmi_pending && irq_pending;
        enter_halt = boundary && !nmi_pending && !irq_pending && halt_op;
        enter_stop = boundary && !nmi_pending && !irq_pending && !halt_op && stop_op;
        run_next   = is_run && !enter_halt && !enter_stop;
    end

    always_comb begin
        tphase_d   = '0;
        wait_cnt_d = '0;
        state_d    = state_q;
        if (is_run) begin
            if (stall) begin
                tphase_d   = tphase_q;
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end else if (!at_last) begin
                tphase_d   = tphase_q + TPH_W'(1);
                wait_cnt_d = wait_cnt_q;
            end
        end
        if (m_end_w) begin
            state_d = (take_nmi || take_irq || cond_fail) ? '0 : state_next;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mode_q    <= RUN;
            clk_ena_q <= 1'b1;
            osc_ena_q <= 1'b1;
            osc_cnt_q <= '0;
        end else if (SYNC_RESET) begin
            mode_q    <= RUN;
            clk_ena_q <= 1'b1;
            osc_ena_q <= 1'b1;
            osc_cnt_q <= '0;
        end else begin
            case (mode_q)
                RUN: begin
                    if (enter_halt) begin
                        mode_q    <= HALT;
                        clk_ena_q <= 1'b0;
                    end else if (enter_stop) begin
                        mode_q    <= STOP;
                        clk_ena_q <= 1'b0;
                        osc_ena_q <= 1'b0;
                    end
                end
                HALT: begin
                    if (irq_pending || nmi_pending) begin
                        mode_q    <= RUN;
                        clk_ena_q <= 1'b1;
                    end
                end
                STOP: begin
                    if (WAKE) begin
                        mode_q    <= OSC_WAIT;
                        osc_ena_q <= 1'b1;
                        osc_cnt_q <= '0;
                    end
                end
                OSC_WAIT: begin
                    if (!OSC_STABLE) begin
                        osc_cnt_q <= '0;
                    end else if (osc_cnt_q == OSC_LAST) begin
                        mode_q    <= RUN;
                        clk_ena_q <= 1'b1;
                        osc_cnt_q <= '0;
                    end else begin
                        osc_cnt_q <= osc_cnt_q + OSC_W'(1);
                    end
                end
                default: begin
                    mode_q    <= RUN;
                    clk_ena_q <= 1'b1;
                    osc_ena_q <= 1'b1;
                    osc_cnt_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tphase_q       <= '0;
            wait_cnt_q     <= '0;
            state_q        <= '0;
            rd_q           <= 1'b0;
            mreq_q         <= 1'b0;
            int_entry_q    <= 1'b0;
            int_is_nmi_q   <= 1'b0;
            wait_timeout_q <= 1'b0;
        end else if (SYNC_RESET) begin
            tphase_q       <= '0;
            wait_cnt_q     <= '0;
            state_q        <= '0;
            rd_q           <= 1'b0;
            mreq_q         <= 1'b0;
            int_entry_q    <= 1'b0;
            int_is_nmi_q   <= 1'b0;
            wait_timeout_q <= 1'b0;
        end else begin
            tphase_q    <= tphase_d;
            wait_cnt_q  <= wait_cnt_d;
            state_q     <= state_d;
            // Strobes are suppressed in the cycle the core leaves RUN.
            mreq_q      <= addr_valid && run_next;
            rd_q        <= addr_valid && bus_rd && run_next && ((tphase_q != TPH_LAST) || stall);
            int_entry_q <= take_nmi || take_irq;
            if (take_nmi || take_irq) begin
                int_is_nmi_q <= take_nmi;
            end
            if (forced) begin
                wait_timeout_q <= 1'b1;
            end
        end
    end

    assign state        = state_q;
    assign tphase       = tphase_q;
    assign m_end        = m_end_w;
    assign mode         = mode_q;
    assign CLK_ENA      = clk_ena_q;
    assign OSC_ENA      = osc_ena_q;
    assign RD           = rd_q;
    assign MREQ         = mreq_q;
    assign int_entry    = int_entry_q;
    assign int_is_nmi   = int_is_nmi_q;
    assign wait_timeout = wait_timeout_q;

endmodule

`default_nettype wire

// File: doc/seq_mcycle_ctrl.md
Name: seq_mcycle_ctrl

Overview:
Parametrised machine-cycle sequencer, successor to the CPU core's fixed 3-bit state sequencer.
- Owns the T-phase counter and the M-cycle state register.
- Inserts bus wait states.
- Runs the RUN/HALT/STOP/OSC_WAIT low-power modes and NMI/IRQ entry at instruction boundaries.
- Sits between the instruction decoder (supplies next state and op flags) and the bus/clock-gating logic (consumes RD, MREQ, CLK_ENA, OSC_ENA).

Parameters:
STATE_W, 3, width of the M-cycle state register.
T_PER_M, 4, T-phases per M-cycle (≥2).
WAIT_MAX, 3, max wait states inserted per M-cycle before a forced advance.
OSC_WAIT_CYCLES, 16, consecutive OSC_STABLE cycles required before leaving OSC_WAIT.

Ports:
CLK  in  1  single core clock, all state updates on the rising edge.
RESET  in  1  asynchronous, active-high reset.
SYNC_RESET  in  1  synchronous soft reset, same effect as RESET on the next edge.
state_next  in  STATE_W  decoder's next M-cycle state.
cond_fail  in  1  ALU condition false; forces state to 0 at m_end.
m_last  in  1  current M-cycle ends the instruction.
halt_op  in  1  HALT decoded, valid with m_last.
stop_op  in  1  STOP decoded, valid with m_last.
addr_valid  in  1  current M-cycle drives the bus.
bus_rd  in  1  bus access is a read.
bus_wait  in  1  target not ready.
irq_pending  in  1  maskable interrupt requested and enabled.
NMI  in  1  asynchronous NMI line, rising-edge triggered.
WAKE  in  1  STOP wake request.
OSC_STABLE  in  1  oscillator stable indication.
state  out  STATE_W  registered M-cycle state.
tphase  out  $clog2(T_PER_M)  current T-phase.
m_end  out  1  last phase of this M-cycle and not stalled.
mode  out  2  0=RUN, 1=HALT, 2=STOP, 3=OSC_WAIT.
CLK_ENA  out  1  core clock gate enable.
OSC_ENA  out  1  oscillator enable.
RD  out  1  bus read strobe.
MREQ  out  1  memory request.
int_entry  out  1  one-cycle pulse: interrupt entry begins.
int_is_nmi  out  1  qualifies int_entry.
wait_timeout  out  1  sticky: a forced advance occurred.

Behaviour:
- Reset (RESET async, or SYNC_RESET at the edge):
  - state=0, tphase=0, mode=RUN, nmi_pending=0, wait counter=0, osc counter=0.
  - CLK_ENA=1, OSC_ENA=1, RD=0, MREQ=0, int_entry=0, wait_timeout=0.
  - All outputs are registered except m_end and tphase decode.
- RUN:
  - tphase increments each cycle and wraps T_PER_M-1 → 0.
  - Stall: at tphase=T_PER_M-1 with addr_valid&bus_wait and wait count<WAIT_MAX, hold tphase and increment the wait count.
  - Forced advance: when wait count=WAIT_MAX, advance anyway and set wait_timeout (cleared only by reset).
  - Wait count clears at m_end.
- m_end = (tphase==T_PER_M-1) & ~stall. On m_end, state <= cond_fail ? 0 : state_next.
- Instruction boundary (m_end & m_last), priority order:
  - nmi_pending → int_entry=1, int_is_nmi=1, clear nmi_pending, state=0.
  - irq_pending → int_entry=1, int_is_nmi=0, state=0.
  - halt_op → mode=HALT.
  - stop_op → mode=STOP.
  - A halt_op with an interrupt already pending never enters HALT; the interrupt is taken.
- HALT:
  - tphase held 0, state held, CLK_ENA=0.
  - irq_pending|nmi_pending → RUN next cycle, CLK_ENA=1, tphase=0.
  - The interrupt is then taken at the next boundary.
- STOP:
  - CLK_ENA=0, OSC_ENA=0.
  - WAKE → OSC_WAIT. NMI edges are still latched but do not wake.
- OSC_WAIT:
  - OSC_ENA=1, CLK_ENA=0.
  - Counter increments while OSC_STABLE=1 and resets to 0 when OSC_STABLE=0.
  - Reaching OSC_WAIT_CYCLES → RUN, tphase=0.
- NMI:
  - 2-flop synchroniser plus edge detect; a rising edge sets nmi_pending.
  - An edge arriving in the same cycle as the clear keeps nmi_pending=1.
- Bus strobes:
  - MREQ <= addr_valid & mode==RUN.
  - RD <= addr_valid & bus_rd & mode==RUN & (tphase<T_PER_M-1 | stall).
  - Both drop to 0 on any mode change or reset mid-cycle.

Decomposition:
- Shared package holds:
  - seq_mode_t enum {RUN, HALT, STOP, OSC_WAIT}.
  - MODE_W=2.
  - localparams for the tphase width.
- One sub-module: seq_nmi_sync (synchroniser, edge detect, pending flag with set-over-clear priority).
- Mode FSM, T-phase/wait counter and strobes stay in the top module.

Test Plan:
- Reset release, state_next=3, no wait → m_end every 4 cycles; state 0→3 at first m_end; MREQ follows addr_valid one cycle later.
- addr_valid=1, bus_wait=1 for 2 cycles → tphase holds 3 for 2 extra cycles; m_end delayed 2; wait_timeout=0. bus_wait held 5 cycles → forced advance after 3; wait_timeout=1.
- m_last+halt_op, irq_pending=0 → mode=1, CLK_ENA=0. irq_pending=1 → mode=0 next cycle. Next boundary gives int_entry=1, int_is_nmi=0.
- NMI pulse plus irq_pending at the same boundary → int_is_nmi=1 first. nmi_pending clear coincident with a new NMI edge → pending remains 1; second entry has int_is_nmi=1.
- stop_op → OSC_ENA=0. WAKE → OSC_ENA=1. OSC_STABLE drops at count 10 → counter restarts; RUN after 16 consecutive stable cycles.
- cond_fail=1 at m_end with state_next=5 → state=0. SYNC_RESET in OSC_WAIT → mode=RUN, OSC_ENA=1, counters 0.
